// File: rtl/spram_pkg.sv
// spram_pkg
//    Shared constants for the parameterised single-port RAM:
//    - WRITE_MODE encodings (read-during-write behaviour)
//    - FSM state encoding (CLEAR / READY)
//    - READ_LAT legality limits
//    - params_legal(): elaboration-time parameter check
package spram_pkg;

   localparam int WM_READ_FIRST  = 0;
   localparam int WM_WRITE_FIRST = 1;
   localparam int WM_NO_CHANGE   = 2;

   localparam int READ_LAT_MIN = 1;
   localparam int READ_LAT_MAX = 2;

   typedef logic [0:0] state_t;

   localparam state_t ST_CLEAR = 1'b0;
   localparam state_t ST_READY = 1'b1;

   function automatic bit params_legal(input int data_w,
                                       input int addr_w,
                                       input int write_mode,
                                       input int read_lat,
                                       input int clear_on_rst);
      return (data_w >= 8) && ((data_w % 8) == 0) &&
             (addr_w >= 1) && (addr_w <= 30) &&
             (write_mode >= WM_READ_FIRST) && (write_mode <= WM_NO_CHANGE) &&
             (read_lat >= READ_LAT_MIN) && (read_lat <= READ_LAT_MAX) &&
             ((clear_on_rst == 0) || (clear_on_rst == 1));
   endfunction

endpackage

// File: rtl/spram_be_merge.sv
// spram_be_merge
//    Byte-lane merge: bytes of din whose be bit is set replace the
//    corresponding bytes of old_word; all other bytes pass through.
//    Ports:
//       old_word  in   current memory word
//       din       in   write data
//       be        in   byte enables, bit i covers byte lane i
//       new_word  out  merged word
module spram_be_merge
   import spram_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0]   old_word,
   input  logic [DATA_W-1:0]   din,
   input  logic [DATA_W/8-1:0] be,
   output logic [DATA_W-1:0]   new_word
);

   localparam int unsigned NB = DATA_W / 8;

   always_comb begin
      new_word = old_word;
      for (int unsigned i = 0; i < NB; i++) begin
         if (be[i]) begin
            new_word[8*i +: 8] = din[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/spram_param.sv
// spram_param
//    Parameterised single-port RAM with byte enables, selectable
//    read-during-write behaviour, 1- or 2-cycle read latency and an optional
//    zero-fill sequence after reset.
//    Ports:
//       clk       in   clock, rising edge
//       rst       in   synchronous active-high reset
//       en        in   access request
//       wr        in   1 = write, 0 = read
//       addr      in   word address
//       din       in   write data
//       be        in   byte write enables
//       dout      out  read data (holds between responses)
//       rd_valid  out  one-cycle pulse when dout carries a fresh response
//       busy      out  clear sequence running; requests are dropped
module spram_param
   import spram_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int ADDR_W       = 4,
   parameter int WRITE_MODE   = 0,
   parameter int READ_LAT     = 1,
   parameter int CLEAR_ON_RST = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                wr,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   din,
   input  logic [DATA_W/8-1:0] be,
   output logic [DATA_W-1:0]   dout,
   output logic                rd_valid,
   output logic                busy
);

   if (!params_legal(DATA_W, ADDR_W, WRITE_MODE, READ_LAT, CLEAR_ON_RST)) begin : g_bad_params
      $error("spram_param: illegal parameter combination");
   end

   localparam int     DEPTH    = 2**ADDR_W;
   localparam state_t ST_RESET = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;

   logic [DATA_W-1:0] mem [DEPTH];

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              rd_valid_q, rd_valid_d;

   logic [DATA_W-1:0] old_word;
   logic [DATA_W-1:0] new_word;
   logic              clr_wr;
   logic              wr_acc;
   logic              rd_acc;
   logic              resp_vld;
   logic [DATA_W-1:0] resp_data;

   assign old_word = mem[addr];

   spram_be_merge #(
      .DATA_W(DATA_W)
   ) u_merge (
      .old_word(old_word),
      .din     (din),
      .be      (be),
      .new_word(new_word)
   );

   // rst gates every array write so reset alone never alters contents.
   assign clr_wr   = !rst && (state_q == ST_CLEAR);
   assign wr_acc   = !rst && (state_q == ST_READY) && en && wr;
   assign rd_acc   = !rst && (state_q == ST_READY) && en && !wr;
   assign resp_vld = rd_acc || (wr_acc && (WRITE_MODE != WM_NO_CHANGE));
   assign resp_data = (wr_acc && (WRITE_MODE == WM_WRITE_FIRST)) ? new_word : old_word;

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (state_q == ST_CLEAR) begin
         clr_cnt_d = clr_cnt_q + 1'b1;
         if (clr_cnt_q == '1) begin
            state_d = ST_READY;
         end
      end
   end

   if (READ_LAT == 1) begin : g_lat1
      always_comb begin
         rd_valid_d = resp_vld;
         dout_d     = resp_vld ? resp_data : dout_q;
      end
   end else begin : g_lat2
      logic              p1_vld_q, p1_vld_d;
      logic [DATA_W-1:0] p1_data_q, p1_data_d;

      always_comb begin
         p1_vld_d   = resp_vld;
         p1_data_d  = resp_vld ? resp_data : p1_data_q;
         rd_valid_d = p1_vld_q;
         dout_d     = p1_vld_q ? p1_data_q : dout_q;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            p1_vld_q  <= 1'b0;
            p1_data_q <= '0;
         end else begin
            p1_vld_q  <= p1_vld_d;
            p1_data_q <= p1_data_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_RESET;
         clr_cnt_q  <= '0;
         dout_q     <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         dout_q     <= dout_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (clr_wr) begin
         mem[clr_cnt_q] <= '0;
      end else if (wr_acc) begin
         mem[addr] <= new_word;
      end
   end

   assign dout     = dout_q;
   assign rd_valid = rd_valid_q;
   // During reset busy reflects the state reset is about to enter.
   assign busy     = rst ? (CLEAR_ON_RST != 0) : (state_q == ST_CLEAR);

endmodule

// File: tb/tb_spram_param.sv
module tb_spram_param;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        wr;
   logic [3:0]  addr;
   logic [31:0] din;
   logic [3:0]  be;

   logic [7:0]  dout0;
   logic [31:0] dout1, dout2, dout3;
   logic        vld0, vld1, vld2, vld3;
   logic        bsy0, bsy1, bsy2, bsy3;

   always #5 clk = ~clk;

   // d0: all defaults (8-bit, READ_FIRST, latency 1)
   spram_param u_d0 (
      .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr),
      .din(din[7:0]), .be(be[0:0]), .dout(dout0), .rd_valid(vld0), .busy(bsy0)
   );

   spram_param #(.DATA_W(32), .ADDR_W(4), .WRITE_MODE(0), .READ_LAT(2), .CLEAR_ON_RST(1)) u_d1 (
      .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr),
      .din(din), .be(be), .dout(dout1), .rd_valid(vld1), .busy(bsy1)
   );

   spram_param #(.DATA_W(32), .ADDR_W(4), .WRITE_MODE(1), .READ_LAT(1), .CLEAR_ON_RST(1)) u_d2 (
      .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr),
      .din(din), .be(be), .dout(dout2), .rd_valid(vld2), .busy(bsy2)
   );

   spram_param #(.DATA_W(32), .ADDR_W(4), .WRITE_MODE(2), .READ_LAT(2), .CLEAR_ON_RST(1)) u_d3 (
      .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr),
      .din(din), .be(be), .dout(dout3), .rd_valid(vld3), .busy(bsy3)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference model: word array, remaining clear cycles, and per instance
   // the response visible on the outputs plus one pending response for
   // the 2-cycle instances.
   logic [31:0] m [16];
   int          clr_left = 0;
   int          mode [4] = '{0, 0, 1, 2};
   int          lat  [4] = '{1, 2, 1, 2};
   logic        exp_v [4];
   logic [31:0] exp_d [4];
   logic        pend_v [4];
   logic [31:0] pend_d [4];
   logic        exp_busy;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step(input logic r, input logic e, input logic w,
                       input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
      logic        rvi [4];
      logic [31:0] rdat [4];
      logic [31:0] old, nw, mask;
      rst = r; en = e; wr = w; addr = a; din = d; be = b;
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 4; i++) begin
         rvi[i]  = 1'b0;
         rdat[i] = '0;
      end
      if (r) begin
         clr_left = 16;
         for (int i = 0; i < 4; i++) begin
            exp_v[i]  = 1'b0;
            exp_d[i]  = '0;
            pend_v[i] = 1'b0;
            pend_d[i] = '0;
         end
      end else begin
         if (clr_left > 0) begin
            m[16 - clr_left] = '0;
            clr_left--;
         end else if (e) begin
            old  = m[a];
            mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
            nw   = (old & ~mask) | (d & mask);
            if (w) begin
               m[a] = nw;
               for (int i = 0; i < 4; i++) begin
                  if (mode[i] != 2) begin
                     rvi[i]  = 1'b1;
                     rdat[i] = (mode[i] == 1) ? nw : old;
                  end
               end
            end else begin
               for (int i = 0; i < 4; i++) begin
                  rvi[i]  = 1'b1;
                  rdat[i] = old;
               end
            end
         end
         for (int i = 0; i < 4; i++) begin
            if (lat[i] == 1) begin
               exp_v[i] = rvi[i];
               if (rvi[i]) exp_d[i] = rdat[i];
            end else begin
               exp_v[i] = pend_v[i];
               if (pend_v[i]) exp_d[i] = pend_d[i];
               pend_v[i] = rvi[i];
               pend_d[i] = rdat[i];
            end
         end
      end
      exp_busy = r ? 1'b1 : (clr_left > 0);
      #1;
      check($sformatf("c%0d d0 busy", cyc), 32'(bsy0), 32'(exp_busy));
      check($sformatf("c%0d d1 busy", cyc), 32'(bsy1), 32'(exp_busy));
      check($sformatf("c%0d d2 busy", cyc), 32'(bsy2), 32'(exp_busy));
      check($sformatf("c%0d d3 busy", cyc), 32'(bsy3), 32'(exp_busy));
      check($sformatf("c%0d d0 rd_valid", cyc), 32'(vld0), 32'(exp_v[0]));
      check($sformatf("c%0d d1 rd_valid", cyc), 32'(vld1), 32'(exp_v[1]));
      check($sformatf("c%0d d2 rd_valid", cyc), 32'(vld2), 32'(exp_v[2]));
      check($sformatf("c%0d d3 rd_valid", cyc), 32'(vld3), 32'(exp_v[3]));
      check($sformatf("c%0d d0 dout", cyc), {24'h0, dout0}, exp_d[0] & 32'h0000_00FF);
      check($sformatf("c%0d d1 dout", cyc), dout1, exp_d[1]);
      check($sformatf("c%0d d2 dout", cyc), dout2, exp_d[2]);
      check($sformatf("c%0d d3 dout", cyc), dout3, exp_d[3]);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
   endtask

   initial begin
      int n;
      rst = 1'b1; en = 1'b0; wr = 1'b0; addr = '0; din = '0; be = '0;

      // Reset, then the initial clear must last exactly 16 cycles.
      step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
      step(1'b1, 1'b1, 1'b1, 4'h2, 32'hFFFF_FFFF, 4'hF);
      n = 0;
      do begin
         idle();
         n++;
      end while (bsy1 && n < 40);
      check("busy_len_initial", 32'(n), 32'd16);

      // Every location reads zero after the clear.
      for (int k = 0; k < 16; k++) step(1'b0, 1'b1, 1'b0, 4'(k), 32'h0, 4'h0);

      // Back-to-back writes then back-to-back reads.
      for (int k = 0; k < 16; k++) step(1'b0, 1'b1, 1'b1, 4'(k), 32'(k), 4'hF);
      for (int k = 0; k < 18; k++) begin
         if (k < 16) step(1'b0, 1'b1, 1'b0, 4'(k), 32'h0, 4'h0);
         else idle();
         if (k < 16) begin
            check("seq_lat1_dout", dout2, 32'(k));
            check("seq_lat1_valid", 32'(vld2), 32'd1);
         end
         if (k >= 1 && k <= 16) begin
            check("seq_lat2_dout", dout1, 32'(k - 1));
            check("seq_lat2_valid", 32'(vld1), 32'd1);
         end
      end

      // Byte-enable merge on a 32-bit word.
      step(1'b0, 1'b1, 1'b1, 4'h3, 32'hAABB_CCDD, 4'hF);
      step(1'b0, 1'b1, 1'b1, 4'h3, 32'h1122_3344, 4'b0101);
      step(1'b0, 1'b1, 1'b0, 4'h3, 32'h0, 4'h0);
      check("be_merge_lat1", dout2, 32'hAA22_CC44);
      idle();
      check("be_merge_lat2", dout1, 32'hAA22_CC44);

      // Read-during-write behaviour.
      step(1'b0, 1'b1, 1'b1, 4'h2, 32'h55, 4'hF);
      step(1'b0, 1'b1, 1'b1, 4'h2, 32'h99, 4'hF);
      check("rdw_read_first", {24'h0, dout0}, 32'h55);
      check("rdw_write_first", dout2, 32'h99);
      idle();
      check("rdw_read_first_lat2", dout1, 32'h55);
      check("rdw_no_change_valid", 32'(vld3), 32'd0);
      check("rdw_no_change_dout", dout3, 32'hAA22_CC44);

      // Zero-byte-enable write leaves memory alone.
      step(1'b0, 1'b1, 1'b1, 4'h2, 32'hFFFF_FFFF, 4'h0);
      step(1'b0, 1'b1, 1'b0, 4'h2, 32'h0, 4'h0);
      check("be_zero", dout2, 32'h99);

      // Randomised traffic with occasional resets.
      for (int k = 0; k < 400; k++) begin
         step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              $urandom, 4'($urandom_range(0, 15)));
      end
      for (int k = 0; k < 20; k++) idle();

      // Reset at clear cycle 7, then a write while busy is dropped.
      step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
      for (int k = 0; k < 7; k++) idle();
      step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
      n = 0;
      do begin
         if (n == 3) step(1'b0, 1'b1, 1'b1, 4'h0, 32'hDEAD_BEEF, 4'hF);
         else idle();
         n++;
      end while (bsy1 && n < 40);
      check("busy_len_restart", 32'(n), 32'd16);
      step(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 4'h0);
      check("dropped_wr_d2", dout2, 32'h0);
      check("dropped_wr_d0", {24'h0, dout0}, 32'h0);

      // Latency-2 read followed by reset yields no rd_valid.
      step(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 4'h0);
      step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
      check("flush_lat2_d1", 32'(vld1), 32'd0);
      check("flush_lat2_d3", 32'(vld3), 32'd0);
      for (int k = 0; k < 3; k++) begin
         idle();
         check("flush_after_d1", 32'(vld1), 32'd0);
         check("flush_after_d3", 32'(vld3), 32'd0);
      end
      for (int k = 0; k < 16; k++) idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
